// File: rtl/seg7_ca_capture.sv
// Common-anode 7-segment receiver: synchronizes, debounces and decodes
// the segment, decimal-point and digit-select lines of one digit.
//
// Ports:
//   clk50MHz     - system clock
//   rst          - synchronous active-high reset
//   Segments     - segment lines a..g (bit0..bit6), active-low
//   dp           - decimal point, active-low
//   SEL7         - digit select, active-low
//   hex_out      - last accepted hex value (0 when glyph unknown)
//   dp_out       - last accepted decimal point, active-high
//   raw_pattern  - last accepted segment pattern, as received
//   valid        - accepted pattern held and digit not blank
//   unknown      - accepted pattern is not a hex glyph
//   blank        - digit deselected for BLANK_CYCLES cycles or more
//   change_pulse - one-cycle strobe when the accepted value changes

module seg7_ca_capture #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned BLANK_CYCLES  = 1024
) (
  input  logic       clk50MHz,
  input  logic       rst,
  input  logic [6:0] Segments,
  input  logic       dp,
  input  logic       SEL7,
  output logic [3:0] hex_out,
  output logic       dp_out,
  output logic [6:0] raw_pattern,
  output logic       valid,
  output logic       unknown,
  output logic       blank,
  output logic       change_pulse
);

  localparam logic [15:0] STABLE_MAX = 16'(STABLE_CYCLES);
  localparam logic [15:0] BLANK_MAX  = 16'(BLANK_CYCLES);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_TRACK,
    ST_LOCKED
  } state_t;

  // {unknown, hex} for a received segment pattern
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b1_0000;
    case (seg)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
      default: r = 5'b1_0000;
    endcase
    return r;
  endfunction

  // sync vectors are {SEL7, dp, Segments}
  logic [8:0]  sync1_q, sync2_q;
  state_t      state_q, state_d;
  logic [7:0]  cand_q, cand_d;
  logic [15:0] stab_q, stab_d;
  logic [15:0] inact_q, inact_d;
  logic [3:0]  hex_q, hex_d;
  logic        dpo_q, dpo_d;
  logic [6:0]  raw_q, raw_d;
  logic        valid_q, valid_d;
  logic        unk_q, unk_d;
  logic        blank_q, blank_d;
  logic        pulse_q, pulse_d;

  logic        s_sel;
  logic [7:0]  s_pat;
  logic [4:0]  dec;

  assign s_sel = sync2_q[8];
  assign s_pat = sync2_q[7:0];
  assign dec   = decode(cand_q[6:0]);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    stab_d  = stab_q;
    inact_d = inact_q;
    hex_d   = hex_q;
    dpo_d   = dpo_q;
    raw_d   = raw_q;
    valid_d = valid_q;
    unk_d   = unk_q;
    blank_d = blank_q;
    pulse_d = 1'b0;

    if (s_sel) begin
      state_d = ST_BLANK;
      stab_d  = '0;
      if (inact_q != BLANK_MAX) begin
        inact_d = inact_q + 16'd1;
      end
      if (inact_q == BLANK_LAST) begin
        valid_d = 1'b0;
        blank_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          state_d = ST_TRACK;
          cand_d  = s_pat;
          stab_d  = 16'd1;
          inact_d = '0;
        end
        ST_TRACK: begin
          if (s_pat != cand_q) begin
            cand_d = s_pat;
            stab_d = 16'd1;
          end else if (stab_q == STABLE_MAX) begin
            // one edge after the count is reached the value is taken
            state_d = ST_LOCKED;
            hex_d   = dec[3:0];
            unk_d   = dec[4];
            raw_d   = cand_q[6:0];
            dpo_d   = ~cand_q[7];
            valid_d = 1'b1;
            blank_d = 1'b0;
            pulse_d = !valid_q ||
                      ({raw_q, dpo_q} != {cand_q[6:0], ~cand_q[7]});
          end else begin
            stab_d = stab_q + 16'd1;
          end
        end
        ST_LOCKED: begin
          if (s_pat != cand_q) begin
            state_d = ST_TRACK;
            cand_d  = s_pat;
            stab_d  = 16'd1;
          end
        end
        default: begin
          state_d = ST_BLANK;
          stab_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      state_q <= ST_BLANK;
      cand_q  <= '1;
      stab_q  <= '0;
      inact_q <= '0;
      hex_q   <= '0;
      dpo_q   <= 1'b0;
      raw_q   <= 7'h7F;
      valid_q <= 1'b0;
      unk_q   <= 1'b0;
      blank_q <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= {SEL7, dp, Segments};
      sync2_q <= sync1_q;
      state_q <= state_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      inact_q <= inact_d;
      hex_q   <= hex_d;
      dpo_q   <= dpo_d;
      raw_q   <= raw_d;
      valid_q <= valid_d;
      unk_q   <= unk_d;
      blank_q <= blank_d;
      pulse_q <= pulse_d;
    end
  end

  assign hex_out      = hex_q;
  assign dp_out       = dpo_q;
  assign raw_pattern  = raw_q;
  assign valid        = valid_q;
  assign unknown      = unk_q;
  assign blank        = blank_q;
  assign change_pulse = pulse_q;

endmodule

// File: tb/tb_seg7_ca_capture.sv
// Directed bench for seg7_ca_capture: reset, latency, glitch,
// decimal point, unknown glyphs, blanking, mid-run reset, glyph sweep.

module tb_seg7_ca_capture;

  logic       clk50MHz = 1'b0;
  logic       rst;
  logic [6:0] Segments;
  logic       dp;
  logic       SEL7;
  logic [3:0] hex_out;
  logic       dp_out;
  logic [6:0] raw_pattern;
  logic       valid;
  logic       unknown;
  logic       blank;
  logic       change_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int p0;

  seg7_ca_capture #(
    .STABLE_CYCLES(16),
    .BLANK_CYCLES (1024)
  ) dut (
    .clk50MHz    (clk50MHz),
    .rst         (rst),
    .Segments    (Segments),
    .dp          (dp),
    .SEL7        (SEL7),
    .hex_out     (hex_out),
    .dp_out      (dp_out),
    .raw_pattern (raw_pattern),
    .valid       (valid),
    .unknown     (unknown),
    .blank       (blank),
    .change_pulse(change_pulse)
  );

  always #10 clk50MHz = ~clk50MHz;

  always @(negedge clk50MHz) begin
    if (change_pulse === 1'b1) pulses <= pulses + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk50MHz);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [3:0] e_hex,
                            input logic e_dp, input logic [6:0] e_raw,
                            input logic e_v, input logic e_unk,
                            input logic e_blk, input logic e_cp);
    cmp({tag, ".hex"},   {28'd0, hex_out},      {28'd0, e_hex});
    cmp({tag, ".dp"},    {31'd0, dp_out},       {31'd0, e_dp});
    cmp({tag, ".raw"},   {25'd0, raw_pattern},  {25'd0, e_raw});
    cmp({tag, ".valid"}, {31'd0, valid},        {31'd0, e_v});
    cmp({tag, ".unk"},   {31'd0, unknown},      {31'd0, e_unk});
    cmp({tag, ".blank"}, {31'd0, blank},        {31'd0, e_blk});
    cmp({tag, ".pulse"}, {31'd0, change_pulse}, {31'd0, e_cp});
  endtask

  logic [6:0] glyph [16];

  initial begin
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst = 1'b1; SEL7 = 1'b1; dp = 1'b1; Segments = 7'h7F;
    tick(5);
    expect_all("reset", 4'h0, 1'b0, 7'h7F, 1'b0, 1'b0, 1'b1, 1'b0);

    // steady digit 0, latency of 18 edges from the first sampling edge
    rst = 1'b0; SEL7 = 1'b0; Segments = 7'h40; dp = 1'b1;
    tick(18);
    cmp("lat0_early", {31'd0, valid}, 32'd0);
    tick(1);
    expect_all("lat0", 4'h0, 1'b0, 7'h40, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);
    cmp("lat0_pulse_off", {31'd0, change_pulse}, 32'd0);
    tick(5);

    // short glitch to 3 then back to 0
    p0 = pulses;
    Segments = 7'h30;
    tick(10);
    Segments = 7'h40;
    tick(30);
    cmp("glitch_hex", {28'd0, hex_out}, 32'h0);
    cmp("glitch_pulses", pulses - p0, 32'd0);

    // hold 3
    Segments = 7'h30;
    tick(18);
    cmp("hold3_early", {28'd0, hex_out}, 32'h0);
    tick(1);
    expect_all("hold3", 4'h3, 1'b0, 7'h30, 1'b1, 1'b0, 1'b0, 1'b1);

    // decimal point with A
    dp = 1'b0; Segments = 7'h08;
    tick(19);
    expect_all("dpA", 4'hA, 1'b1, 7'h08, 1'b1, 1'b0, 1'b0, 1'b1);

    // unknown glyph
    dp = 1'b1; Segments = 7'h55;
    tick(19);
    expect_all("unk55", 4'h0, 1'b0, 7'h55, 1'b1, 1'b1, 1'b0, 1'b1);

    // all segments off while selected
    Segments = 7'h7F;
    tick(19);
    expect_all("off7F", 4'h0, 1'b0, 7'h7F, 1'b1, 1'b1, 1'b0, 1'b1);

    // lock on 5 before the blanking tests
    Segments = 7'h12;
    tick(20);
    expect_all("lock5", 4'h5, 1'b0, 7'h12, 1'b1, 1'b0, 1'b0, 1'b0);

    // deselect gap one short of the blank threshold
    p0 = pulses;
    SEL7 = 1'b1;
    tick(1023);
    cmp("gap1023_valid", {31'd0, valid}, 32'd1);
    cmp("gap1023_blank", {31'd0, blank}, 32'd0);
    SEL7 = 1'b0;
    tick(40);
    expect_all("gap1023_after", 4'h5, 1'b0, 7'h12, 1'b1, 1'b0, 1'b0,
               1'b0);
    cmp("gap1023_pulses", pulses - p0, 32'd0);

    // deselect gap exactly at the blank threshold
    SEL7 = 1'b1;
    tick(1024);
    SEL7 = 1'b0;
    tick(2);
    expect_all("gap1024", 4'h5, 1'b0, 7'h12, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(16);
    cmp("reselect_early", {31'd0, valid}, 32'd0);
    tick(1);
    expect_all("reselect", 4'h5, 1'b0, 7'h12, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(5);

    // reset at count 10 of tracking a new value
    Segments = 7'h30;
    tick(12);
    rst = 1'b1;
    tick(1);
    expect_all("rst_mid", 4'h0, 1'b0, 7'h7F, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    tick(18);
    cmp("reacq_early", {31'd0, valid}, 32'd0);
    tick(1);
    expect_all("reacq", 4'h3, 1'b0, 7'h30, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(2);

    // all sixteen glyphs
    p0 = pulses;
    for (int i = 0; i < 16; i++) begin
      Segments = glyph[i];
      tick(20);
      cmp($sformatf("sweep%0d.hex", i), {28'd0, hex_out}, 32'(i));
      cmp($sformatf("sweep%0d.unk", i), {31'd0, unknown}, 32'd0);
      cmp($sformatf("sweep%0d.valid", i), {31'd0, valid}, 32'd1);
    end
    cmp("sweep_pulses", pulses - p0, 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
